// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with 64-byte lines.
// Read misses fill a whole line from dataMemory; every store is forwarded to dataMemory.
module data_cache #(
    parameter int NUM_LINES  = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic [31:0]  cpuAddress,
    input  logic         cpuRead,
    input  logic         cpuWrite,
    input  logic [31:0]  cpuWriteData,
    output logic [31:0]  cpuReadData,
    output logic         cpuStall,
    output logic [31:0]  memReadAddress,
    input  logic         memReadEnable,
    input  logic [511:0] memDataOut,
    output logic [31:0]  memWriteAddress,
    output logic         memWriteRequest,
    output logic [31:0]  memWriteData,
    input  logic         memWriteDone
);
    localparam int TAG_BITS = 32 - 6 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SETUP, S_RD_TRIG, S_RD_ACCEPT, S_RD_WAIT, S_WR_REQ, S_WR_WAIT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
    logic [511:0]         r_data [NUM_LINES];

    logic [31:0] r_mem_read_address;
    logic [31:0] r_mem_write_address;
    logic [31:0] r_mem_write_data;
    logic        r_mem_write_request;
    logic        r_done_low_seen;

    logic [INDEX_BITS-1:0] w_cpu_index;
    logic [TAG_BITS-1:0]   w_cpu_tag;
    logic [3:0]            w_word_sel;
    logic [8:0]            w_word_offset;
    logic                  w_hit;
    logic [511:0]          w_line;
    logic [31:0]           w_hit_word;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic                  w_write_done;

    assign w_cpu_index   = cpuAddress[6+INDEX_BITS-1:6];
    assign w_cpu_tag     = cpuAddress[31:6+INDEX_BITS];
    assign w_word_sel    = cpuAddress[5:2];
    assign w_word_offset = {w_word_sel, 5'b00000};
    assign w_hit         = r_valid[w_cpu_index] && (r_tag[w_cpu_index] == w_cpu_tag);
    assign w_line        = r_data[w_cpu_index];
    assign w_hit_word    = w_line[w_word_offset +: 32];
    // The fill targets the line latched into the read address, not the live CPU address.
    assign w_fill_index  = r_mem_read_address[6+INDEX_BITS-1:6];
    assign w_fill_tag    = r_mem_read_address[31:6+INDEX_BITS];
    assign w_write_done  = r_done_low_seen && memWriteDone;

    assign memReadAddress  = r_mem_read_address;
    assign memWriteAddress = r_mem_write_address;
    assign memWriteData    = r_mem_write_data;
    assign memWriteRequest = r_mem_write_request;

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the combinational stall and load-data outputs.
    always_comb begin
        w_next_state = r_state;
        cpuStall     = 1'b0;
        cpuReadData  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (cpuWrite) begin
                    w_next_state = S_WR_REQ;
                    cpuStall     = 1'b1;
                end else if (cpuRead) begin
                    if (w_hit) begin
                        cpuReadData = w_hit_word;
                    end else begin
                        w_next_state = S_RD_SETUP;
                        cpuStall     = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD_SETUP: begin
                w_next_state = S_RD_TRIG;
                cpuStall     = 1'b1;
            end
            S_RD_TRIG: begin
                w_next_state = S_RD_ACCEPT;
                cpuStall     = 1'b1;
            end
            S_RD_ACCEPT: begin
                cpuStall = 1'b1;
                if (!memReadEnable) begin
                    w_next_state = S_RD_WAIT;
                end else begin
                    w_next_state = S_RD_ACCEPT;
                end
            end
            S_RD_WAIT: begin
                cpuStall = 1'b1;
                if (memReadEnable) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RD_WAIT;
                end
            end
            S_WR_REQ: begin
                w_next_state = S_WR_WAIT;
                cpuStall     = 1'b1;
            end
            S_WR_WAIT: begin
                if (w_write_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    cpuStall = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Memory-side handshake registers and line valid bits.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_valid             <= '0;
            r_mem_read_address  <= 32'd0;
            r_mem_write_address <= 32'd0;
            r_mem_write_data    <= 32'd0;
            r_mem_write_request <= 1'b0;
            r_done_low_seen     <= 1'b0;
        end else begin
            case (r_state)
                S_RD_SETUP: r_mem_read_address <= {cpuAddress[31:6], 6'b000000};
                // Bit 0 rising is the edge dataMemory starts a read on.
                S_RD_TRIG:  r_mem_read_address <= {r_mem_read_address[31:6], 6'b000001};
                S_RD_WAIT: begin
                    if (memReadEnable) begin
                        r_valid[w_fill_index] <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    r_mem_write_address <= cpuAddress;
                    r_mem_write_data    <= cpuWriteData;
                    r_mem_write_request <= 1'b1;
                    r_done_low_seen     <= 1'b0;
                end
                S_WR_WAIT: begin
                    if (!memWriteDone) begin
                        r_done_low_seen <= 1'b1;
                    end
                    if (w_write_done) begin
                        r_mem_write_request <= 1'b0;
                    end
                end
                default: begin
                    r_mem_read_address <= r_mem_read_address;
                end
            endcase
        end
    end

    // Tag and data arrays: line fill on read completion, word update on store hit.
    always_ff @(posedge clock) begin
        if ((r_state == S_RD_WAIT) && memReadEnable) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= memDataOut;
        end else if ((r_state == S_WR_REQ) && w_hit) begin
            r_data[w_cpu_index][w_word_offset +: 32] <= cpuWriteData;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: dataMemory responder, directed vector table, reset-abort sequence and
// randomized traffic checked against a line-level reference model of the cache and memory.
module tb_data_cache;
    logic         clock = 1'b0;
    logic         resetN;
    logic [31:0]  cpuAddress;
    logic         cpuRead;
    logic         cpuWrite;
    logic [31:0]  cpuWriteData;
    logic [31:0]  cpuReadData;
    logic         cpuStall;
    logic [31:0]  memReadAddress;
    logic         memReadEnable;
    logic [511:0] memDataOut;
    logic [31:0]  memWriteAddress;
    logic         memWriteRequest;
    logic [31:0]  memWriteData;
    logic         memWriteDone;

    data_cache dut (
        .clock(clock), .resetN(resetN),
        .cpuAddress(cpuAddress), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
        .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .cpuStall(cpuStall),
        .memReadAddress(memReadAddress), .memReadEnable(memReadEnable), .memDataOut(memDataOut),
        .memWriteAddress(memWriteAddress), .memWriteRequest(memWriteRequest),
        .memWriteData(memWriteData), .memWriteDone(memWriteDone)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Backing store: mem_m holds what the DUT wrote, ref_mem what the bench intended.
    logic [31:0] mem_m   [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned wi);
        return (wi * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [31:0] iw(input logic [31:0] a);
        return init_word(a >> 2);
    endfunction

    function automatic logic [31:0] mem_word(input int unsigned wi);
        return mem_m.exists(wi) ? mem_m[wi] : init_word(wi);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned wi);
        return ref_mem.exists(wi) ? ref_mem[wi] : init_word(wi);
    endfunction

    // dataMemory responder, acting on the falling edge.
    int          rd_starts = 0;
    int          wr_starts = 0;
    int          gap_viol  = 0;
    int          wr_low    = 1;
    int          rd_cnt    = 0;
    int          wr_cnt    = 0;
    bit          rd_busy   = 1'b0;
    bit          wr_busy   = 1'b0;
    bit          prev_rd0  = 1'b0;
    bit          prev_wreq = 1'b0;
    logic [31:0] rd_line;
    logic [31:0] wr_a;
    logic [31:0] wr_d;

    always @(negedge clock) begin
        if (memReadAddress[0] && !prev_rd0) begin
            rd_busy = 1'b1;
            rd_cnt = $urandom_range(1, 6);
            rd_line = memReadAddress;
            memReadEnable = 1'b0;
            rd_starts++;
        end else if (rd_busy) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                for (int w = 0; w < 16; w++) begin
                    memDataOut[w*32 +: 32] = mem_word((rd_line >> 6) * 16 + w);
                end
                memReadEnable = 1'b1;
                rd_busy = 1'b0;
            end
        end
        prev_rd0 = memReadAddress[0];

        if (memWriteRequest && !prev_wreq) begin
            if (wr_low == 0) gap_viol++;
            wr_starts++;
            memWriteDone = 1'b0;
            wr_busy = 1'b1;
            wr_cnt = $urandom_range(1, 6);
            wr_a = memWriteAddress;
            wr_d = memWriteData;
        end else if (wr_busy) begin
            wr_cnt--;
            if (wr_cnt == 0) begin
                mem_m[wr_a >> 2] = wr_d;
                memWriteDone = 1'b1;
                wr_busy = 1'b0;
            end
        end
        if (memWriteRequest) wr_low = 0;
        else wr_low++;
        prev_wreq = memWriteRequest;
    end

    // Reference cache: one valid flag and tag per index, line = addr/64.
    bit          ref_valid [16];
    int unsigned ref_tag   [16];

    function automatic bit ref_hit(input logic [31:0] a);
        int unsigned line = a >> 6;
        return ref_valid[line % 16] && (ref_tag[line % 16] == line / 16);
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    endtask

    // One CPU transaction; called 1 time unit after a rising edge.
    task automatic cpu_op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int cycles, output int fills,
                          output bit timeout);
        int f0 = rd_starts;
        cycles = 0;
        timeout = 1'b0;
        rdata = 32'd0;
        cpuAddress = a;
        cpuWriteData = d;
        cpuWrite = wr;
        cpuRead = !wr;
        while (1) begin
            #6;
            if (!cpuStall) begin
                rdata = cpuReadData;
                break;
            end
            cycles++;
            if (cycles > 500) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        cpuRead = 1'b0;
        cpuWrite = 1'b0;
        fills = rd_starts - f0;
    endtask

    task automatic apply_read(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_data);
        logic [31:0] rd;
        int cyc, fills;
        bit to;
        int unsigned line = a >> 6;
        cpu_op(1'b0, a, 32'd0, rd, cyc, fills, to);
        check_int("rd_timeout", int'(to), 0);
        check32("rd_data", rd, exp_data);
        if (exp_hit) begin
            check_int("hit_stall_cycles", cyc, 0);
            check_int("hit_mem_reads", fills, 0);
        end else begin
            check_int("miss_mem_reads", fills, 1);
        end
        ref_valid[line % 16] = 1'b1;
        ref_tag[line % 16] = line / 16;
    endtask

    task automatic apply_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int cyc, fills;
        bit to;
        int w0 = wr_starts;
        cpu_op(1'b1, a, d, rd, cyc, fills, to);
        check_int("wr_timeout", int'(to), 0);
        check_int("wr_stalled", int'(cyc > 0), 1);
        check_int("wr_requests", wr_starts - w0, 1);
        check_int("wr_mem_reads", fills, 0);
        check32("wr_mem_word", mem_word(a >> 2), d);
        ref_mem[a >> 2] = d;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetN = 1'b0;
        cpuAddress = 32'd0;
        cpuRead = 1'b0;
        cpuWrite = 1'b0;
        cpuWriteData = 32'd0;
        memReadEnable = 1'b1;
        memWriteDone = 1'b1;
        memDataOut = '0;
        clear_ref();

        vecs.push_back('{1'b0, 32'h40,  32'd0,         1'b0, iw(32'h40)});
        vecs.push_back('{1'b0, 32'h44,  32'd0,         1'b1, iw(32'h44)});
        vecs.push_back('{1'b1, 32'h44,  32'hDEADBEEF,  1'b0, 32'd0});
        vecs.push_back('{1'b0, 32'h44,  32'd0,         1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h400, 32'h12345678,  1'b0, 32'd0});
        vecs.push_back('{1'b0, 32'h400, 32'd0,         1'b0, 32'h12345678});
        vecs.push_back('{1'b1, 32'h444, 32'h0BADF00D,  1'b0, 32'd0});
        vecs.push_back('{1'b0, 32'h48,  32'd0,         1'b1, iw(32'h48)});
        vecs.push_back('{1'b0, 32'h440, 32'd0,         1'b0, iw(32'h440)});
        vecs.push_back('{1'b0, 32'h444, 32'd0,         1'b1, 32'h0BADF00D});
        vecs.push_back('{1'b0, 32'h40,  32'd0,         1'b0, iw(32'h40)});
        vecs.push_back('{1'b0, 32'h44,  32'd0,         1'b1, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 32'h7C,  32'd0,         1'b1, iw(32'h7C)});
        vecs.push_back('{1'b0, 32'h7F,  32'd0,         1'b1, iw(32'h7C)});
        vecs.push_back('{1'b1, 32'h80,  32'h11111111,  1'b0, 32'd0});
        vecs.push_back('{1'b1, 32'h84,  32'h22222222,  1'b0, 32'd0});
        vecs.push_back('{1'b0, 32'h84,  32'd0,         1'b0, 32'h22222222});
        vecs.push_back('{1'b0, 32'h80,  32'd0,         1'b1, 32'h11111111});

        repeat (2) @(posedge clock);
        #1;
        check32("rst_memReadAddress", memReadAddress, 32'd0);
        check32("rst_memWriteAddress", memWriteAddress, 32'd0);
        check32("rst_memWriteData", memWriteData, 32'd0);
        check_int("rst_memWriteRequest", int'(memWriteRequest), 0);
        check_int("rst_cpuStall", int'(cpuStall), 0);
        check32("rst_cpuReadData", cpuReadData, 32'd0);
        resetN = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) apply_write(vecs[i].addr, vecs[i].wdata);
            else apply_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data);
        end

        // Reset while the line fill is outstanding.
        cpuAddress = 32'h100;
        cpuRead = 1'b1;
        n = 0;
        while (memReadEnable && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check_int("abort_fill_started", int'(memReadEnable), 0);
        resetN = 1'b0;
        cpuRead = 1'b0;
        clear_ref();
        #6;
        check_int("abort_cpuStall", int'(cpuStall), 0);
        check_int("abort_memWriteRequest", int'(memWriteRequest), 0);
        check32("abort_memReadAddress", memReadAddress, 32'd0);
        @(posedge clock); #1;
        resetN = 1'b1;
        n = 0;
        while (!memReadEnable && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check_int("abort_mem_idle", int'(memReadEnable), 1);
        repeat (3) @(posedge clock);
        #1;
        apply_read(32'h100, 1'b0, ref_word(32'h100 >> 2));
        apply_read(32'h40, 1'b0, ref_word(32'h40 >> 2));

        // Randomized traffic over a few indices and tags so hits, misses and evictions mix.
        for (int i = 0; i < 300; i++) begin
            int unsigned line = $urandom_range(0, 2) * 16 + $urandom_range(0, 3);
            logic [31:0] a = line * 64 + $urandom_range(0, 63);
            if ($urandom_range(0, 2) == 0) apply_write(a, $urandom);
            else apply_read(a, ref_hit(a), ref_word(a >> 2));
        end

        check_int("write_request_gap_violations", gap_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
